// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
// Holds the read-mode enum and the compare-based pointer wrap.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Wraps at depth-1 by compare so any depth works, not just powers of two
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Register-array storage: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read is zero-latency; no flow control of its own.
module fifo_regfile #(
    parameter int DATA_W = 8,
    parameter int FIFO_D = 32,
    parameter int PTR_W  = $clog2(FIFO_D)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [FIFO_D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard (1-cycle) or FWFT reads, programmable almost flags,
// sticky overflow/underflow and sync flush; writes when full only pass alongside a read.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FIFO_D = 32,
    parameter int FWFT   = 0,
    parameter int CNT_W  = $clog2(FIFO_D + 1),
    parameter int PTR_W  = $clog2(FIFO_D)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [CNT_W-1:0]  af_thresh,
    input  logic [CNT_W-1:0]  ae_thresh,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  data_avail,
    output logic [CNT_W-1:0]  room_avail,
    output logic              overflow,
    output logic              underflow
);

    localparam fifo_mode_e      MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_D);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_fifo;
    logic              wr_fifo;

    assign rd_fifo = rd_en && (count != '0);
    assign wr_fifo = wr_en && ((count != DEPTH) || rd_fifo);

    fifo_regfile #(
        .DATA_W (DATA_W),
        .FIFO_D (FIFO_D),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk    (clk),
        .we     (wr_fifo && !clr),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .raddr  (rd_ptr),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_fifo) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), 32'(FIFO_D)));
            end
            if (rd_fifo) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), 32'(FIFO_D)));
            end
            if (wr_fifo && !rd_fifo) begin
                count <= count + 1'b1;
            end else if (rd_fifo && !wr_fifo) begin
                count <= count - 1'b1;
            end
            if (wr_en && !wr_fifo) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_fifo) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [DATA_W-1:0] data_q;
            logic              vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else if (clr) begin
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_fifo;
                    if (rd_fifo) begin
                        data_q <= mem_rdata;
                    end
                end
            end

            assign rd_data  = data_q;
            assign rd_valid = vld_q;
        end else begin : g_fwft
            // Head word is shown straight from storage; a pop just advances rd_ptr
            assign rd_data  = mem_rdata;
            assign rd_valid = (count != '0);
        end
    endgenerate

    assign fifo_full    = (count == DEPTH);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);
    assign data_avail   = count;
    assign room_avail   = DEPTH - count;

endmodule
